// File: rtl/fifo_sample_reader_if.sv
// Read-port bundle between the sample FIFO and its reader.
// master: reader (drives fifo_rd_en); slave: FIFO (drives empty/fill/data).
interface fifo_sample_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                         fifo_rd_en;
    logic                         fifo_empty;
    logic        [ADDR_WIDTH:0]   fifo_fill;
    logic signed [DATA_WIDTH-1:0] fifo_data;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_fill,
        input  fifo_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_fill,
        output fifo_data
    );
endinterface

// File: rtl/fifo_sample_reader.sv
// Sample FIFO read controller: one pop per sample_tick, prefill, underrun count.
// Ports: clk, rst_a_n (async, active-low), enable, sample_tick,
//   fifo (read-port interface, master side), sample_out/sample_valid (stream
//   to serializer, valid 2 cycles after tick), underrun pulse,
//   underrun_count (saturating), state_run.
// Build option FIFO_READER_HOLD_EN: non-read ticks repeat the last FIFO
//   sample instead of outputting zero.
module fifo_sample_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int START_LEVEL = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_a_n,
    input  logic                         enable,
    input  logic                         sample_tick,
    fifo_sample_reader_if.master         fifo,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_valid,
    output logic                         underrun,
    output logic        [CNT_WIDTH-1:0]  underrun_count,
    output logic                         state_run
);

    typedef enum logic [1:0] {
        IDLE,
        PREFILL,
        RUN
    } state_t;

    localparam logic [ADDR_WIDTH:0] START_LVL =
        (ADDR_WIDTH+1)'(START_LEVEL);

    state_t                       state;
    logic                         rd_pend;
    logic                         fill_pend;
    logic                         in_run;
    logic                         urun;
    logic signed [DATA_WIDTH-1:0] fill_val;

    assign in_run    = (state == RUN);
    assign state_run = in_run;

    // Never pop an empty FIFO: its pointer moves on rd_en regardless.
    assign fifo.fifo_rd_en = sample_tick & in_run & ~fifo.fifo_empty;
    assign urun            = sample_tick & in_run & fifo.fifo_empty;

`ifdef FIFO_READER_HOLD_EN
    logic signed [DATA_WIDTH-1:0] last_sample;
    assign fill_val = last_sample;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n)
            last_sample <= '0;
        else if (rd_pend)
            last_sample <= fifo.fifo_data;
    end
`else
    assign fill_val = '0;
`endif

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state          <= IDLE;
            rd_pend        <= 1'b0;
            fill_pend      <= 1'b0;
            sample_out     <= '0;
            sample_valid   <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            // Both read and non-read ticks use the same two-stage timing
            // so the downstream sees a uniform tick-to-valid latency.
            rd_pend      <= fifo.fifo_rd_en;
            fill_pend    <= sample_tick & ~fifo.fifo_rd_en;
            sample_valid <= rd_pend | fill_pend;
            underrun     <= urun;

            if (rd_pend)
                sample_out <= fifo.fifo_data;
            else if (fill_pend)
                sample_out <= fill_val;

            if (urun && underrun_count != '1)
                underrun_count <= underrun_count + 1'b1;

            if (!enable) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE:    state <= PREFILL;
                    PREFILL: if (fifo.fifo_fill >= START_LVL)
                                 state <= RUN;
                    RUN:     if (urun)
                                 state <= PREFILL;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Scoreboard bench for fifo_sample_reader with a behavioural sample FIFO.
// Stimulus queues expected samples; a negedge monitor checks value/latency.
module tb_fifo_sample_reader;

    typedef struct {
        logic [15:0] v;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_tick = 1'b0;
    logic signed [15:0] sample_out;
    logic        sample_valid;
    logic        underrun;
    logic [1:0]  underrun_count;
    logic        state_run;

    logic        push_en = 1'b0;
    logic [15:0] push_val = '0;
    logic [15:0] q[$];
    exp_t        exq[$];
    exp_t        me;
    logic [15:0] last_rd = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    fifo_sample_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) fif ();

    fifo_sample_reader #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .START_LEVEL(8),
        .CNT_WIDTH  (2)
    ) dut (
        .clk           (clk),
        .rst_a_n       (rst_a_n),
        .enable        (enable),
        .sample_tick   (sample_tick),
        .fifo          (fif),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .underrun      (underrun),
        .underrun_count(underrun_count),
        .state_run     (state_run)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        fif.fifo_fill = '0;
        fif.fifo_data = '0;
    end

    assign fif.fifo_empty = (fif.fifo_fill == 0);

    // Behavioural FIFO: registered read data, one cycle after rd_en.
    always @(posedge clk) begin
        if (fif.fifo_rd_en) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_on_empty got=1 want=0");
            end else begin
                fif.fifo_data <= q.pop_front();
            end
        end
        if (push_en)
            q.push_back(push_val);
        fif.fifo_fill <= 5'(q.size());
    end

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_a_n && sample_valid) begin
            if (exq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid got=%h want=none",
                         sample_out);
            end else begin
                me = exq.pop_front();
                chk("sample", {16'h0, sample_out}, {16'h0, me.v});
                chk("latency", 32'(cyc), 32'(me.c));
            end
        end
    end

    function automatic logic [15:0] fv(logic [15:0] last);
`ifdef FIFO_READER_HOLD_EN
        return last;
`else
        return 16'h0 & last;
`endif
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(logic [15:0] v);
        push_en  = 1'b1;
        push_val = v;
        step(1);
        push_en  = 1'b0;
    endtask

    task automatic tick(logic rd, logic [15:0] v, logic want);
        exp_t e;
        sample_tick = 1'b1;
        #1;
        chk("rd_en", {31'h0, fif.fifo_rd_en}, {31'h0, rd});
        if (rd)
            last_rd = v;
        if (want) begin
            e.v = v;
            e.c = cyc + 2;
            exq.push_back(e);
        end
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!state_run && n < 10) begin
            step(1);
            n++;
        end
        chk("reach_run", {31'h0, state_run}, 32'h1);
    endtask

    logic [15:0] d [8];
    logic [15:0] v;

    initial begin
        d = '{16'h0001, 16'h0002, 16'hFFFB, 16'h0004,
              16'h0005, 16'h0006, 16'h0007, 16'h1234};

        #2;
        chk("rst_out", {16'h0, sample_out}, 32'h0);
        chk("rst_valid", {31'h0, sample_valid}, 32'h0);
        chk("rst_urun", {31'h0, underrun}, 32'h0);
        chk("rst_cnt", {30'h0, underrun_count}, 32'h0);
        chk("rst_run", {31'h0, state_run}, 32'h0);
        step(2);
        rst_a_n = 1'b1;
        step(1);

        // Prefill: 7 samples is below start level.
        enable = 1'b1;
        for (int i = 0; i < 7; i++)
            push(d[i]);
        tick(1'b0, fv(last_rd), 1'b1);
        step(2);
        tick(1'b0, fv(last_rd), 1'b1);
        step(2);
        chk("prefill_fill", {27'h0, fif.fifo_fill}, 32'd7);
        chk("prefill_run", {31'h0, state_run}, 32'h0);

        // 8th sample; the tick in the transition cycle is a prefill tick.
        push(d[7]);
        tick(1'b0, fv(last_rd), 1'b1);
        chk("enter_run", {31'h0, state_run}, 32'h1);

        // Spaced streaming.
        tick(1'b1, d[0], 1'b1);
        step(3);
        tick(1'b1, d[1], 1'b1);
        chk("fill_6", {27'h0, fif.fifo_fill}, 32'd6);
        step(3);
        tick(1'b1, d[2], 1'b1);
        chk("fill_5", {27'h0, fif.fifo_fill}, 32'd5);
        step(3);

        // Back-to-back ticks.
        tick(1'b1, d[3], 1'b1);
        tick(1'b1, d[4], 1'b1);
        tick(1'b1, d[5], 1'b1);
        chk("fill_2", {27'h0, fif.fifo_fill}, 32'd2);
        tick(1'b1, d[6], 1'b1);
        tick(1'b1, d[7], 1'b1);

        // Underrun.
        tick(1'b0, fv(last_rd), 1'b1);
        chk("urun_pulse", {31'h0, underrun}, 32'h1);
        chk("urun_cnt1", {30'h0, underrun_count}, 32'd1);
        chk("urun_prefill", {31'h0, state_run}, 32'h0);
        step(1);
        chk("urun_1cyc", {31'h0, underrun}, 32'h0);
        step(2);

        // Four more underruns: counter saturates at 3.
        for (int k = 2; k <= 5; k++) begin
            for (int i = 0; i < 8; i++)
                push(16'(k * 256 + i));
            wait_run();
            for (int i = 0; i < 8; i++)
                tick(1'b1, 16'(k * 256 + i), 1'b1);
            tick(1'b0, fv(last_rd), 1'b1);
            chk("sat_pulse", {31'h0, underrun}, 32'h1);
            chk("sat_cnt", {30'h0, underrun_count},
                (k < 3) ? 32'(k) : 32'd3);
            step(2);
        end

        // Disable right after a read: the capture still completes.
        for (int i = 0; i < 8; i++)
            push(16'h2000 + 16'(i));
        wait_run();
        tick(1'b1, 16'h2000, 1'b1);
        enable = 1'b0;
        step(2);
        chk("dis_idle", {31'h0, state_run}, 32'h0);
        tick(1'b0, fv(last_rd), 1'b1);
        step(3);

        // Reset mid-read: pending sample is discarded.
        enable = 1'b1;
        push(16'h3000);
        wait_run();
        v = q[0];
        tick(1'b1, v, 1'b0);
        rst_a_n = 1'b0;
        #1;
        chk("mr_out", {16'h0, sample_out}, 32'h0);
        chk("mr_valid", {31'h0, sample_valid}, 32'h0);
        chk("mr_cnt", {30'h0, underrun_count}, 32'h0);
        chk("mr_run", {31'h0, state_run}, 32'h0);
        step(3);
        rst_a_n = 1'b1;
        step(4);
        chk("sb_empty", 32'(exq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_sample_reader.md
Name: fifo_sample_reader

Overview:
Read-side controller for the team's synchronous sample FIFO. Pops one signed audio sample per sample-rate tick and presents it to the downstream DAC/I2S transmitter path as a one-cycle valid pulse. Handles the FIFO's registered one-cycle read latency, prefills to a start level before playback, and detects and counts underruns. It sits between the FIFO's read port and the output serializer.

Parameters:
DATA_WIDTH, 16, sample width, signed; must match the FIFO's data width.
ADDR_WIDTH, 4, FIFO address width; fill-level input is ADDR_WIDTH+1 bits.
START_LEVEL, 8, fill level (1..2^ADDR_WIDTH) required to leave PREFILL.
CNT_WIDTH, 16, width of the saturating underrun counter.

Ports:
clk  in  1  system clock, rising edge
rst_a_n  in  1  asynchronous reset, active-low
enable  in  1  playback enable, level
sample_tick  in  1  one-cycle strobe at audio sample rate
fifo_empty  in  1  FIFO empty flag
fifo_fill  in  ADDR_WIDTH+1  FIFO fill count
fifo_data  in  DATA_WIDTH signed  FIFO data_out; valid the cycle after fifo_rd_en
fifo_rd_en  out  1  FIFO read enable, combinational
sample_out  out  DATA_WIDTH signed  output sample, registered
sample_valid  out  1  one-cycle pulse, sample_out is new
underrun  out  1  one-cycle pulse on each underrun event
underrun_count  out  CNT_WIDTH  saturating underrun count
state_run  out  1  high while in RUN

Behaviour:
- Reset (rst_a_n=0, asynchronous): state=IDLE; sample_out=0, sample_valid=0, underrun=0, underrun_count=0, internal read-pending flag=0. fifo_rd_en is 0 because it is gated by state.
- States:
  - IDLE: waits for enable=1, then goes to PREFILL.
  - PREFILL: goes to RUN when fifo_fill >= START_LEVEL, evaluated every cycle.
  - RUN: normal playback.
- Leaving any state: enable=0 sends the FSM to IDLE on the next edge. This has priority over all other transitions.
- fifo_rd_en = sample_tick & (state==RUN) & !fifo_empty. It is never asserted when empty, because the FIFO advances its pointer on rd_en regardless.
- Read path:
  - A tick with a read at cycle T sets the pending flag.
  - At the end of T+1, fifo_data is captured into sample_out.
  - sample_valid is high for exactly cycle T+2, so the latency is 2 cycles from tick to valid.
  - Back-to-back ticks are legal and fully pipelined, one sample per cycle.
- Ticks in IDLE or PREFILL: sample_out is loaded with 0 and sample_valid pulses 2 cycles later. This keeps the downstream stream continuous. No FIFO read occurs.
- Underrun: a tick in RUN with fifo_empty=1.
  - No read is issued.
  - The underrun pulse is high at T+1.
  - underrun_count increments and saturates at all-ones.
  - sample_out gets the fill value (see the optional feature), with sample_valid at T+2.
  - The FSM returns to PREFILL at T+1.
- Disable or reset mid-operation:
  - If enable falls while a read is pending, the capture still completes and sample_valid still pulses, so the FIFO data is not lost.
  - Asynchronous reset discards the pending read.
- The tick that causes the PREFILL->RUN transition in the same cycle is treated as a PREFILL tick (zero output). The first FIFO read happens on the next tick.
- underrun_count is cleared only by reset.

Optional Feature:
FIFO_READER_HOLD_EN.
- Defined: on underrun, sample_out repeats the last sample read from the FIFO. PREFILL ticks also repeat it.
- Undefined: underrun and PREFILL ticks output 0.
- In both cases the value after reset is 0.

Test Plan:
- Prefill: enable=1, push 7 samples, apply ticks -> sample_out=0 with valid each tick, no fifo_rd_en. Push an 8th sample -> RUN; the next tick reads.
- Streaming: FIFO holds 1,2,...,10, tick every 4 cycles -> sample_out 1,2,3... each valid exactly 2 cycles after its tick, fifo_fill decrements per tick.
- Back-to-back: 3 consecutive tick cycles with fill=8 -> valid pulses on 3 consecutive cycles with values in FIFO order, fill=5.
- Underrun: in RUN with last sample 0x1234, FIFO empty, tick -> fifo_rd_en=0, underrun pulse, count=1, sample_out=0 (0x1234 with FIFO_READER_HOLD_EN), state back to PREFILL.
- Saturation: CNT_WIDTH=2, force 5 underruns -> underrun_count=3.
- Disable and reset: drop enable the cycle after a read -> valid still pulses with the FIFO value, then IDLE. Assert rst_a_n=0 mid-read -> all outputs 0 immediately, no valid pulse.
